// File: rtl/aes_pkg.sv
// aes_pkg: FSM encodings, frame length and AES byte-level helpers
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } spi_state_e;

    typedef enum logic [1:0] {
        PH_RX  = 2'd0,
        PH_RUN = 2'd1,
        PH_OUT = 2'd2
    } slave_phase_e;

    // Frame length with a 128-bit key: mode bit + data block + key.
    // Longer keys add 32 bits per extra key word.
    localparam int unsigned F = 1 + 128 + 4 * 32;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    // Round constant for key-expansion step i (1-based).
    function automatic logic [7:0] rcon(input int i);
        logic [7:0] r;
        if (i >= 1 && i <= 10) r = RCON_TABLE[(10 - i) * 8 +: 8];
        else r = 8'h00;
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else p = p;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // State bytes: byte 0 in bits [127:120]; byte (4*col + row).
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = 128'd0;
        for (int i = 0; i < 16; i++)
            o[i * 8 +: 8] = inv ? inv_sbox(s[i * 8 +: 8]) : sbox(s[i * 8 +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[(15 - (4 * c + r)) * 8 +: 8] = s[(15 - (4 * src + r)) * 8 +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;
        o = 128'd0;
        m0 = inv ? 8'd14 : 8'd2;
        m1 = inv ? 8'd11 : 8'd3;
        m2 = inv ? 8'd13 : 8'd1;
        m3 = inv ? 8'd9  : 8'd1;
        for (int c = 0; c < 4; c++) begin
            a0 = s[(15 - 4 * c) * 8 +: 8];
            a1 = s[(14 - 4 * c) * 8 +: 8];
            a2 = s[(13 - 4 * c) * 8 +: 8];
            a3 = s[(12 - 4 * c) * 8 +: 8];
            o[(15 - 4 * c) * 8 +: 8] = gmul(a0, m0) ^ gmul(a1, m1) ^ gmul(a2, m2) ^ gmul(a3, m3);
            o[(14 - 4 * c) * 8 +: 8] = gmul(a0, m3) ^ gmul(a1, m0) ^ gmul(a2, m1) ^ gmul(a3, m2);
            o[(13 - 4 * c) * 8 +: 8] = gmul(a0, m2) ^ gmul(a1, m3) ^ gmul(a2, m0) ^ gmul(a3, m1);
            o[(12 - 4 * c) * 8 +: 8] = gmul(a0, m1) ^ gmul(a1, m2) ^ gmul(a2, m3) ^ gmul(a3, m0);
        end
        return o;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (!last) t = mix_columns(t, 1'b0);
        else t = t;
        return t ^ rk;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk;
        if (!last) t = mix_columns(t, 1'b1);
        else t = t;
        return t;
    endfunction

endpackage

// File: rtl/aes_spi_slave.sv
// aes_spi_slave: receives the serial frame, runs the iterative AES core
// (1 load + Nr rounds + 1 output register) and shifts the result back out.
module aes_spi_slave
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic mosi,
    output logic miso
);

    localparam int FB = int'(F) + (Nk - 4) * 32;
    localparam int KB = Nk * 32;
    localparam int NW = 4 * (Nr + 1);
    localparam int CW = $clog2(FB + 1);

    // Full key schedule; word 0 sits in the top 32 bits.
    function automatic logic [NW*32-1:0] expand_key(input logic [KB-1:0] k);
        logic [31:0] w [NW];
        logic [31:0] t;
        logic [NW*32-1:0] o;
        o = {(NW * 32){1'b0}};
        for (int i = 0; i < Nk; i++) w[i] = k[(Nk - 1 - i) * 32 +: 32];
        for (int i = Nk; i < NW; i++) begin
            t = w[i - 1];
            if (i % Nk == 0) t = sub_word(rot_word(t)) ^ {rcon(i / Nk), 24'h000000};
            else if (Nk > 6 && i % Nk == 4) t = sub_word(t);
            else t = t;
            w[i] = w[i - Nk] ^ t;
        end
        for (int i = 0; i < NW; i++) o[(NW - 1 - i) * 32 +: 32] = w[i];
        return o;
    endfunction

    slave_phase_e     phase_r;
    logic [FB-1:0]    frame_r;
    logic [CW-1:0]    cnt_r;
    logic [3:0]       rnd_r;
    logic [127:0]     st_r;
    logic [127:0]     res_r;
    logic             mode_r;
    logic [NW*32-1:0] sched_s;
    logic [3:0]       rk_idx_s;
    logic [127:0]     rk_s;

    assign sched_s = expand_key(frame_r[KB-1:0]);
    assign miso    = res_r[127];

    // Pick the round key for the load step or the current round.
    always_comb begin
        rk_idx_s = 4'd0;
        if (phase_r == PH_RX) rk_idx_s = frame_r[FB-1] ? 4'd0 : 4'(Nr);
        else if (rnd_r <= 4'(Nr)) rk_idx_s = mode_r ? rnd_r : (4'(Nr) - rnd_r);
        else rk_idx_s = 4'd0;
        rk_s = sched_s[(Nr - int'(rk_idx_s)) * 128 +: 128];
    end

    // Frame capture, cipher iteration and result shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_RX;
            frame_r <= {FB{1'b0}};
            cnt_r   <= {CW{1'b0}};
            rnd_r   <= 4'd0;
            st_r    <= 128'd0;
            res_r   <= 128'd0;
            mode_r  <= 1'b0;
        end else begin
            case (phase_r)
                PH_RX: begin
                    if (!cs_n) begin
                        frame_r <= {frame_r[FB-2:0], mosi};
                        if (cnt_r != CW'(FB)) cnt_r <= cnt_r + CW'(1);
                    end else if (cnt_r == CW'(FB)) begin
                        // Frame complete and link released: load step.
                        mode_r  <= frame_r[FB-1];
                        st_r    <= frame_r[FB-2 -: 128] ^ rk_s;
                        rnd_r   <= 4'd1;
                        cnt_r   <= {CW{1'b0}};
                        phase_r <= PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (rnd_r <= 4'(Nr)) begin
                        st_r  <= mode_r ? enc_round(st_r, rk_s, rnd_r == 4'(Nr))
                                        : dec_round(st_r, rk_s, rnd_r == 4'(Nr));
                        rnd_r <= rnd_r + 4'd1;
                    end else begin
                        res_r   <= st_r;
                        phase_r <= PH_OUT;
                    end
                end
                PH_OUT: begin
                    if (!cs_n) begin
                        res_r <= {res_r[126:0], 1'b0};
                        if (cnt_r == CW'(127)) begin
                            cnt_r   <= {CW{1'b0}};
                            phase_r <= PH_RX;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                default: phase_r <= PH_RX;
            endcase
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// aes_spi_master: frames mode/data/key to the AES slave over an internal
// serial link and collects the 128-bit result onto a parallel output.
module aes_spi_master
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic            sel_encrypt,
    input  logic            sel_decrypt,
    input  logic            clk_master,
    input  logic            rst,
    input  logic [127:0]    data_in,
    input  logic [Nk*32-1:0] key,
    output logic            done_out,
    output logic [127:0]    data_out
);

    localparam int FB = int'(F) + (Nk - 4) * 32;
    localparam int CW = $clog2(FB);

    spi_state_e    state_r;
    spi_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          start_s;
    logic          mode_s;
    logic [FB-1:0] tx_sr_r;
    logic [126:0]  rx_sr_r;
    logic          cs_n_r;
    logic          mosi_s;
    logic          miso_s;

    assign mosi_s = tx_sr_r[FB-1];

    // Next state and phase down-counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        mode_s      = 1'b1;
        case (state_r)
            IDLE: begin
                if (sel_encrypt) begin
                    state_nxt_s = SEND;
                    cnt_nxt_s   = CW'(FB - 1);
                    start_s     = 1'b1;
                    mode_s      = 1'b1;
                end else if (sel_decrypt) begin
                    state_nxt_s = SEND;
                    cnt_nxt_s   = CW'(FB - 1);
                    start_s     = 1'b1;
                    mode_s      = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = CW'(Nr + 1);
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = RECV;
                    cnt_nxt_s   = CW'(127);
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            RECV: begin
                if (cnt_r == {CW{1'b0}}) state_nxt_s = DONE;
                else cnt_nxt_s = cnt_r - CW'(1);
            end
            DONE: begin
                if (!sel_encrypt && !sel_decrypt) state_nxt_s = IDLE;
                else state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State register plus registered link select and done flag.
    always_ff @(posedge clk_master or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            cs_n_r   <= 1'b1;
            done_out <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            cs_n_r   <= !(state_nxt_s == SEND || state_nxt_s == RECV);
            done_out <= (state_nxt_s == DONE);
        end
    end

    // TX/RX shift registers and the result output register.
    always_ff @(posedge clk_master or negedge rst) begin
        if (!rst) begin
            tx_sr_r  <= {FB{1'b0}};
            rx_sr_r  <= 127'd0;
            data_out <= 128'd0;
        end else begin
            if (start_s) tx_sr_r <= {mode_s, data_in, key};
            else if (state_r == SEND) tx_sr_r <= {tx_sr_r[FB-2:0], 1'b0};
            if (state_r == RECV) rx_sr_r <= {rx_sr_r[125:0], miso_s};
            // Only a complete 128-bit result ever reaches data_out.
            if (state_r == RECV && state_nxt_s == DONE) data_out <= {rx_sr_r, miso_s};
        end
    end

    aes_spi_slave #(
        .Nk(Nk),
        .Nr(Nr)
    ) u_slave (
        .clk   (clk_master),
        .rst_n (rst),
        .cs_n  (cs_n_r),
        .mosi  (mosi_s),
        .miso  (miso_s)
    );

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master: FIPS-197 vectors, latency, select
// handling, mid-operation reset and a 256-bit key instance.
module tb_aes_spi_master;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk_master = 1'b0;
    logic         rst;
    logic         sel_encrypt, sel_decrypt;
    logic [127:0] data_in;
    logic [127:0] key4;
    logic         done_out;
    logic [127:0] data_out;

    logic         sel_enc8, sel_dec8;
    logic [127:0] data_in8;
    logic [255:0] key8;
    logic         done8;
    logic [127:0] dout8;

    int checks = 0;
    int passes = 0;
    int cyc;

    always #5 clk_master = ~clk_master;

    aes_spi_master #(.Nk(4), .Nr(10)) u_dut4 (
        .sel_encrypt (sel_encrypt),
        .sel_decrypt (sel_decrypt),
        .clk_master  (clk_master),
        .rst         (rst),
        .data_in     (data_in),
        .key         (key4),
        .done_out    (done_out),
        .data_out    (data_out)
    );

    aes_spi_master #(.Nk(8), .Nr(14)) u_dut8 (
        .sel_encrypt (sel_enc8),
        .sel_decrypt (sel_dec8),
        .clk_master  (clk_master),
        .rst         (rst),
        .data_in     (data_in8),
        .key         (key8),
        .done_out    (done8),
        .data_out    (dout8)
    );

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Count rising edges until done rises; first edge counted is number 1.
    task automatic wait_done(input bit use8, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk_master);
            n++;
            #1;
        end while (!(use8 ? done8 : done_out) && n < max);
    endtask

    initial begin
        rst = 1'b0;
        sel_encrypt = 1'b0; sel_decrypt = 1'b0;
        data_in = 128'd0; key4 = K128;
        sel_enc8 = 1'b0; sel_dec8 = 1'b0;
        data_in8 = 128'd0; key8 = K256;

        // Reset state (edge at t=5 occurs with rst low)
        #6;
        check_bit("reset_done", done_out, 1'b0);
        check_vec("reset_data", data_out, 128'd0);
        check_bit("reset_done8", done8, 1'b0);

        // Encrypt
        rst = 1'b1;
        data_in = PT;
        sel_encrypt = 1'b1;
        wait_done(1'b0, 600, cyc);
        check_int("enc_latency", cyc, 398);
        check_bit("enc_done", done_out, 1'b1);
        check_vec("enc_data", data_out, CT128);

        // Result held while the select stays high
        repeat (3) @(posedge clk_master);
        #1;
        check_bit("hold_done", done_out, 1'b1);
        check_vec("hold_data", data_out, CT128);

        // Selects low: done falls, data holds
        sel_encrypt = 1'b0;
        @(posedge clk_master);
        #1;
        check_bit("release_done", done_out, 1'b0);
        check_vec("release_data", data_out, CT128);

        // Decrypt
        data_in = CT128;
        sel_decrypt = 1'b1;
        wait_done(1'b0, 600, cyc);
        check_int("dec_latency", cyc, 398);
        check_bit("dec_done", done_out, 1'b1);
        check_vec("dec_data", data_out, PT);

        sel_decrypt = 1'b0;
        @(posedge clk_master);
        #1;
        check_bit("dec_release_done", done_out, 1'b0);

        // Both selects high: encrypt wins
        data_in = PT;
        sel_encrypt = 1'b1;
        sel_decrypt = 1'b1;
        wait_done(1'b0, 600, cyc);
        check_int("both_latency", cyc, 398);
        check_bit("both_done", done_out, 1'b1);
        check_vec("both_data", data_out, CT128);

        // Back-to-back: one low cycle, then encrypt again
        sel_encrypt = 1'b0;
        sel_decrypt = 1'b0;
        @(posedge clk_master);
        #1;
        check_bit("b2b_gap_done", done_out, 1'b0);
        sel_encrypt = 1'b1;
        wait_done(1'b0, 600, cyc);
        check_int("b2b_latency", cyc, 398);
        check_bit("b2b_done", done_out, 1'b1);
        check_vec("b2b_data", data_out, CT128);

        // Reset mid-operation at cycle 150
        sel_encrypt = 1'b0;
        @(posedge clk_master);
        #1;
        sel_encrypt = 1'b1;
        repeat (150) @(posedge clk_master);
        #1;
        rst = 1'b0;
        #1;
        check_bit("midrst_done", done_out, 1'b0);
        check_vec("midrst_data", data_out, 128'd0);
        #2;
        rst = 1'b1;
        wait_done(1'b0, 600, cyc);
        check_int("post_rst_latency", cyc, 398);
        check_bit("post_rst_done", done_out, 1'b1);
        check_vec("post_rst_data", data_out, CT128);

        // 256-bit key instance
        data_in8 = PT;
        sel_enc8 = 1'b1;
        wait_done(1'b1, 800, cyc);
        check_int("k256_latency", cyc, 530);
        check_bit("k256_done", done8, 1'b1);
        check_vec("k256_data", dout8, CT256);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes_spi_master.md
# aes_spi_master

SPI-style master that frames a mode bit, a 128-bit block and an AES key into a serial stream for an on-chip AES slave. It collects the 128-bit result back serially and presents it on a parallel output with a done flag. It sits between the parallel host interface (`data_in`, `key`, select lines) and the AES cipher datapath. The SPI link is internal, point-to-point and clocked by `clk_master`.

## Interface
- `Nk`, default 4: key length in 32-bit words; legal values 4, 6, 8.
- `Nr`, default 10: round count; must be 10, 12 or 14, matching `Nk`.
- `clk_master`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `sel_encrypt`  in  1: request an encryption.
- `sel_decrypt`  in  1: request a decryption.
- `data_in`  in  128: plaintext or ciphertext, FIPS-197 byte order (MSB = byte 0).
- `key`  in  Nk*32: cipher key, MSB = key byte 0.
- `done_out`  out  1: result valid.
- `data_out`  out  128: result block.

## Operation
- Port order of the interface: `sel_encrypt`, `sel_decrypt`, `clk_master`, `rst`, `data_in`, `key`, `done_out`, `data_out`.
- FSM states are IDLE, SEND, WAIT, RECV and DONE.
- **IDLE**
  - If `sel_encrypt` = 1: latch mode = encrypt, latch `data_in` and `key` into the TX shift register, go to SEND.
  - Else if `sel_decrypt` = 1: latch mode = decrypt, latch the same registers, go to SEND.
  - `sel_encrypt` wins when both selects are high.
  - Inputs are not sampled again until the next IDLE.
- **SEND**
  - Assert internal `cs_n` = 0.
  - Shift F = 1 + 128 + Nk*32 bits, MSB-first, one bit per clock on `mosi`.
  - Frame order: mode bit (1 = encrypt), then `data_in[127:0]`, then `key`.
  - A down-counter reaching 0 moves the FSM to WAIT.
- **WAIT**
  - `cs_n` = 1.
  - The slave runs the iterative cipher for exactly Nr+2 cycles: 1 load, Nr rounds, 1 output register.
  - After those cycles, go to RECV.
- **RECV**
  - `cs_n` = 0.
  - Shift 128 bits, MSB-first, from `miso` into the RX register.
  - After bit 0, go to DONE.
- **DONE**
  - `data_out` = RX register; `done_out` = 1.
  - Both stay stable while `sel_encrypt` or `sel_decrypt` is high.
  - When both selects are low, return to IDLE on the next edge; `done_out` falls and `data_out` holds its value.
- The slave is a behavioural peer inside this block. It shifts in the frame, invokes the AES encrypt or decrypt datapath, and shifts the 128-bit result out.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State = IDLE, `done_out` = 0, `data_out` = 0, `cs_n` = 1, all shift registers and counters cleared.
- Latency is measured from the first rising edge with `rst` high and a select high, to `done_out` high: 1 + F + (Nr+2) + 128 cycles.
  - For Nk = 4, Nr = 10: 1 + 257 + 12 + 128 = 398 cycles.
- Reset asserted mid-operation aborts immediately; no partial result ever appears on `data_out`.
- Select changes during SEND, WAIT or RECV are ignored.
- A new request needs both selects to be low for at least one cycle after DONE.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box and inverse S-box constants;
  - the Rcon table;
  - the state enum (IDLE, SEND, WAIT, RECV, DONE);
  - the localparam F.
- One sub-module, `aes_spi_slave`. It contains the RX frame register, the existing codebase AES cipher/inverse-cipher core and the TX result register.
- The master holds only the FSM, counters and shift registers.

## Test plan
- Encrypt, Nk = 4, Nr = 10:
  - Stimulus: `data_in` = 00112233445566778899aabbccddeeff, `key` = 000102030405060708090a0b0c0d0e0f, `sel_encrypt` = 1, `rst` released after 6 time units.
  - Response: `done_out` rises after 398 cycles and `data_out` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt, same key:
  - Stimulus: `data_in` = 69c4e0d86a7b0430d8cdb78070b4c55a, `sel_decrypt` = 1.
  - Response: `data_out` = 00112233445566778899aabbccddeeff.
- Both selects high, same vectors:
  - Response: the encrypt result, 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reset mid-operation:
  - Stimulus: drop `rst` at cycle 150.
  - Response: `done_out` = 0, `data_out` = 0 immediately; after release, a full 398-cycle run completes correctly.
- Back-to-back requests:
  - Stimulus: after DONE, drop both selects for 1 cycle, then encrypt again.
  - Response: `done_out` falls for at least 1 cycle, then rises again with the correct result.
- Nk = 8, Nr = 14:
  - Stimulus: `key` = 000102…1e1f, plaintext 00112233445566778899aabbccddeeff, encrypt.
  - Response: `data_out` = 8ea2b7ca516745bfeafc49904b496089, latency 1 + 385 + 16 + 128 = 530 cycles.
